ccip_tid_allocator: RTL and testbench
=====================================

Name: ccip_tid_allocator

Overview:
- Transmit-side tag source for the CCI-P TX request stream.
- Assigns a unique transaction ID (tid) to every non-fence request header. Holds each tid as outstanding until the matching response retires it.
- Flags any response whose tid is not outstanding.
- Sits at the request-generation end of the same tid-tagged stream that the passive stream checker watches.

Parameters:
- HDR_WIDTH, CCIP_TX_HDR_WIDTH: request header/meta width.
- TID_WIDTH, 6: tid width. Number of tags NUM_TIDS = 2**TID_WIDTH.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request header presented.
- req_meta  in  HDR_WIDTH  request header; type field at `TX_META_TYPERANGE.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- alloc_valid  out  1  registered: accepted request issued.
- alloc_meta  out  HDR_WIDTH  registered copy of the accepted header.
- alloc_tid  out  TID_WIDTH  registered tid assigned; 0 for WRFENCE.
- rsp_valid  in  1  response returning.
- rsp_tid  in  TID_WIDTH  tid of the returning response.
- rsp_retire  out  1  registered pulse: rsp_tid was outstanding and is now freed.
- err_unknown_tid  out  1  registered pulse: rsp_tid was not outstanding.
- err_tid  out  TID_WIDTH  registered rsp_tid captured with err_unknown_tid.
- outstanding_cnt  out  TID_WIDTH+1  number of tids currently in use.
- init_done  out  1  free list populated; allocator live.

Behaviour:
- Reset values:
  - all outputs 0; init_done=0.
  - FSM=INIT; free-list head, tail and count = 0; in-use bitmap all 0.
- Reset asserted mid-operation clears all state immediately, regardless of traffic. Outstanding tids are forgotten. A response arriving after reset and before reissue reports err_unknown_tid.
- FSM:
  - INIT: writes tag value init_ptr into free-list slot init_ptr, one per cycle, init_ptr 0..NUM_TIDS-1. req_ready=0. rsp_valid is ignored: no retire, no error.
  - INIT -> RUN after the write of NUM_TIDS-1. init_done=1 from the first RUN cycle onward. Init therefore lasts exactly NUM_TIDS cycles after rst deasserts.
- Free list:
  - circular FIFO of NUM_TIDS entries.
  - head/tail are TID_WIDTH bits and wrap modulo NUM_TIDS.
  - free_count is TID_WIDTH+1 bits; it equals NUM_TIDS after init.
- req_ready (combinational):
  - RUN && (meta type == CCIP_WRFENCE || free_count != 0).
  - Fences never stall.
- Accept of a non-fence request:
  - pop the free-list head: tid = fifo[head], head+1, free_count-1.
  - set inuse[tid]; outstanding_cnt+1.
  - next cycle: alloc_valid=1, alloc_meta=req_meta, alloc_tid=tid.
- Accept of a fence: alloc_valid=1 next cycle, alloc_tid=0, no pop, no bitmap change, counts unchanged.
- Response in RUN:
  - if inuse[rsp_tid]: clear the bit, push rsp_tid at tail, tail+1, free_count+1, outstanding_cnt-1. rsp_retire pulses next cycle.
  - else: no state change. err_unknown_tid=1 and err_tid=rsp_tid next cycle.
- Pulse width: every output pulse lasts exactly one cycle and is 0 when there is no event.
- Simultaneous accept and response, same cycle:
  - both take effect; free_count and outstanding_cnt net unchanged.
  - in-use test uses the pre-edge bitmap. A response for the tid being allocated in that same cycle is an error.
  - a tid freed in cycle N is not allocatable before cycle N+1 (no bypass).
- Full list: free_count==0 forces req_ready=0 for non-fence requests. A retire in cycle N makes req_ready rise in cycle N+1.
- Invariant: free_count + outstanding_cnt == NUM_TIDS in RUN. A violation fires a simulation-only $display error.
- Tid order: tids issue in FIFO order of freeing. After init the issue order is 0,1,2,...

Test Plan (TID_WIDTH=3, NUM_TIDS=8):
- Release rst, hold req_valid=1 with non-fence meta -> req_ready=0 for exactly 8 cycles, then init_done=1. alloc_tid sequence 0..7 on consecutive cycles, outstanding_cnt reaches 8, req_ready=0.
- All 8 outstanding, rsp_valid with rsp_tid=5 -> rsp_retire pulse, outstanding_cnt=7, req_ready=1 next cycle; next alloc_tid=5.
- RUN, rsp_tid=3 while tid 3 is free -> err_unknown_tid pulse with err_tid=3; outstanding_cnt and free list unchanged.
- Free list empty, WRFENCE request -> accepted immediately; alloc_valid=1, alloc_tid=0, outstanding_cnt stays 8.
- Same cycle: accept a request that gets tid 2, and rsp_tid=6 (outstanding) -> tid 2 issued, 6 retired, outstanding_cnt unchanged. Separately, rsp_tid equal to the tid allocated that same cycle -> err_unknown_tid.
- Assert rst asynchronously with 4 outstanding -> outputs 0 and outstanding_cnt=0 without a clock edge; after release, 8-cycle init repeats and the first alloc_tid=0.

Source files
------------

// File: rtl/ccip_tid_allocator.sv
// CCI-P TX tag source: hands out tids from a circular free list and
// retires them on response, flagging responses for tids not in flight.
`ifndef CCIP_TX_HDR_WIDTH
`define CCIP_TX_HDR_WIDTH 16
`endif
`ifndef TX_META_TYPERANGE
`define TX_META_TYPERANGE 3:0
`endif

module ccip_tid_allocator #(
    parameter int HDR_WIDTH = `CCIP_TX_HDR_WIDTH,
    parameter int TID_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [HDR_WIDTH-1:0] req_meta,
    output logic                 req_ready,
    output logic                 alloc_valid,
    output logic [HDR_WIDTH-1:0] alloc_meta,
    output logic [TID_WIDTH-1:0] alloc_tid,
    input  logic                 rsp_valid,
    input  logic [TID_WIDTH-1:0] rsp_tid,
    output logic                 rsp_retire,
    output logic                 err_unknown_tid,
    output logic [TID_WIDTH-1:0] err_tid,
    output logic [TID_WIDTH:0]   outstanding_cnt,
    output logic                 init_done
);
    localparam int NUM_TIDS = 2**TID_WIDTH;
    localparam logic [3:0] WRFENCE_TYPE = 4'h4;

    typedef enum logic {INIT, RUN} state_e;

    state_e               state_q, state_d;
    logic [TID_WIDTH-1:0] init_ptr_q, init_ptr_d;
    logic [TID_WIDTH-1:0] head_q, head_d;
    logic [TID_WIDTH-1:0] tail_q, tail_d;
    logic [TID_WIDTH:0]   free_cnt_q, free_cnt_d;
    logic [TID_WIDTH:0]   out_cnt_q, out_cnt_d;
    logic [NUM_TIDS-1:0]  inuse_q, inuse_d;
    logic [TID_WIDTH-1:0] fifo_q [NUM_TIDS];

    logic                 alloc_valid_q;
    logic [HDR_WIDTH-1:0] alloc_meta_q;
    logic [TID_WIDTH-1:0] alloc_tid_q;
    logic                 retire_q;
    logic                 err_q;
    logic [TID_WIDTH-1:0] err_tid_q;

    logic                 running;
    logic                 is_fence;
    logic                 accept;
    logic                 pop;
    logic [TID_WIDTH-1:0] pop_tid;
    logic                 rsp_hit;
    logic                 rsp_miss;

    assign running   = (state_q == RUN);
    assign is_fence  = (req_meta[`TX_META_TYPERANGE] == WRFENCE_TYPE);
    assign req_ready = running && (is_fence || free_cnt_q != '0);
    assign accept    = req_valid && req_ready;
    assign pop       = accept && !is_fence;
    assign pop_tid   = fifo_q[head_q];
    // In-use test sees the pre-edge bitmap, so a same-cycle alloc is unknown
    assign rsp_hit   = running && rsp_valid && inuse_q[rsp_tid];
    assign rsp_miss  = running && rsp_valid && !inuse_q[rsp_tid];

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        head_d     = head_q;
        tail_d     = tail_q;
        free_cnt_d = free_cnt_q;
        out_cnt_d  = out_cnt_q;
        inuse_d    = inuse_q;
        unique case (state_q)
            INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == TID_WIDTH'(NUM_TIDS - 1)) begin
                    state_d    = RUN;
                    free_cnt_d = (TID_WIDTH+1)'(NUM_TIDS);
                end
            end
            RUN: begin
                if (pop) begin
                    head_d           = head_q + 1'b1;
                    inuse_d[pop_tid] = 1'b1;
                end
                if (rsp_hit) begin
                    tail_d           = tail_q + 1'b1;
                    inuse_d[rsp_tid] = 1'b0;
                end
                if (pop && !rsp_hit) begin
                    free_cnt_d = free_cnt_q - 1'b1;
                    out_cnt_d  = out_cnt_q + 1'b1;
                end else if (rsp_hit && !pop) begin
                    free_cnt_d = free_cnt_q + 1'b1;
                    out_cnt_d  = out_cnt_q - 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= INIT;
            init_ptr_q    <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            free_cnt_q    <= '0;
            out_cnt_q     <= '0;
            inuse_q       <= '0;
            alloc_valid_q <= 1'b0;
            alloc_meta_q  <= '0;
            alloc_tid_q   <= '0;
            retire_q      <= 1'b0;
            err_q         <= 1'b0;
            err_tid_q     <= '0;
        end else begin
            state_q       <= state_d;
            init_ptr_q    <= init_ptr_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            free_cnt_q    <= free_cnt_d;
            out_cnt_q     <= out_cnt_d;
            inuse_q       <= inuse_d;
            alloc_valid_q <= accept;
            alloc_meta_q  <= accept ? req_meta : '0;
            alloc_tid_q   <= pop ? pop_tid : '0;
            retire_q      <= rsp_hit;
            err_q         <= rsp_miss;
            err_tid_q     <= rsp_miss ? rsp_tid : '0;
        end
    end

    // Tag storage needs no reset: INIT rewrites every slot before use
    always_ff @(posedge clk) begin
        if (state_q == INIT)
            fifo_q[init_ptr_q] <= init_ptr_q;
        else if (rsp_hit)
            fifo_q[tail_q] <= rsp_tid;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && running &&
            ({1'b0, free_cnt_q} + {1'b0, out_cnt_q}) != (TID_WIDTH+2)'(NUM_TIDS))
            $display("ccip_tid_allocator: error, free %0d + outstanding %0d != %0d",
                     free_cnt_q, out_cnt_q, NUM_TIDS);
    end
`endif

    assign alloc_valid     = alloc_valid_q;
    assign alloc_meta      = alloc_meta_q;
    assign alloc_tid       = alloc_tid_q;
    assign rsp_retire      = retire_q;
    assign err_unknown_tid = err_q;
    assign err_tid         = err_tid_q;
    assign outstanding_cnt = out_cnt_q;
    assign init_done       = running;

endmodule

// File: tb/tb_ccip_tid_allocator.sv
// Bench for ccip_tid_allocator: directed scenarios then random traffic,
// checked against a queue-based free-list model.
module tb_ccip_tid_allocator;
    localparam int TW = 3;
    localparam int HW = 16;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [HW-1:0] req_meta;
    logic          req_ready;
    logic          alloc_valid;
    logic [HW-1:0] alloc_meta;
    logic [TW-1:0] alloc_tid;
    logic          rsp_valid;
    logic [TW-1:0] rsp_tid;
    logic          rsp_retire;
    logic          err_unknown_tid;
    logic [TW-1:0] err_tid;
    logic [TW:0]   outstanding_cnt;
    logic          init_done;

    ccip_tid_allocator #(.HDR_WIDTH(HW), .TID_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_meta(req_meta), .req_ready(req_ready),
        .alloc_valid(alloc_valid), .alloc_meta(alloc_meta), .alloc_tid(alloc_tid),
        .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_retire(rsp_retire),
        .err_unknown_tid(err_unknown_tid), .err_tid(err_tid),
        .outstanding_cnt(outstanding_cnt), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: free tags in freeing order, in-flight flags, init countdown
    int free_q[$];
    bit busy[N];
    bit run;
    int init_left;
    int cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HW-1:0] nf_meta();
        logic [HW-1:0] m;
        m = HW'($urandom);
        if (m[3:0] == 4'h4) m[3:0] = 4'h1;
        return m;
    endfunction

    function automatic logic [HW-1:0] fence_meta();
        logic [HW-1:0] m;
        m = HW'($urandom);
        m[3:0] = 4'h4;
        return m;
    endfunction

    task automatic model_reset();
        run = 1'b0;
        init_left = N;
        cnt = 0;
        free_q.delete();
        for (int i = 0; i < N; i++) busy[i] = 1'b0;
    endtask

    task automatic step(input bit v, input logic [HW-1:0] meta, input bit rv, input int rt);
        bit fence, exp_ready, exp_av, hit, miss;
        int exp_tid;
        req_valid = v;
        req_meta  = meta;
        rsp_valid = rv;
        rsp_tid   = TW'(rt);
        #1;
        fence     = (meta[3:0] == 4'h4);
        exp_ready = run && (fence || free_q.size() != 0);
        chk("req_ready", req_ready, exp_ready);
        chk("init_done", init_done, run);
        exp_av  = v && exp_ready;
        exp_tid = 0;
        hit  = run && rv && busy[rt];
        miss = run && rv && !busy[rt];
        if (exp_av && !fence) begin
            exp_tid = free_q.pop_front();
            busy[exp_tid] = 1'b1;
            cnt++;
        end
        if (hit) begin
            busy[rt] = 1'b0;
            free_q.push_back(rt);
            cnt--;
        end
        if (!run) begin
            init_left--;
            if (init_left == 0) begin
                run = 1'b1;
                for (int i = 0; i < N; i++) free_q.push_back(i);
            end
        end
        @(posedge clk);
        #1;
        chk("alloc_valid", alloc_valid, exp_av);
        if (exp_av) begin
            chk("alloc_tid", alloc_tid, exp_tid);
            chk("alloc_meta", alloc_meta, meta);
        end
        chk("rsp_retire", rsp_retire, hit);
        chk("err_unknown_tid", err_unknown_tid, miss);
        if (miss) chk("err_tid", err_tid, rt);
        chk("outstanding_cnt", outstanding_cnt, cnt);
    endtask

    initial begin
        bit v, rv, f;
        rst = 1'b1;
        req_valid = 1'b0;
        req_meta = '0;
        rsp_valid = 1'b0;
        rsp_tid = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alloc_valid", alloc_valid, 0);
        chk("rst_outstanding", outstanding_cnt, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_retire", rsp_retire, 0);
        chk("rst_err", err_unknown_tid, 0);
        rst = 1'b0;

        // Init (8 cycles stalled) then tids 0..7, then full
        repeat (N + N + 1) step(1'b1, nf_meta(), 1'b0, 0);
        chk("full_cnt", outstanding_cnt, N);

        step(1'b0, '0, 1'b1, 5);
        step(1'b1, nf_meta(), 1'b0, 0);

        // Retire 3, then a second response for the now-free 3
        step(1'b0, '0, 1'b1, 3);
        step(1'b0, '0, 1'b1, 3);
        step(1'b1, nf_meta(), 1'b0, 0);

        // Full list: fence passes, ordinary request stalls
        step(1'b1, fence_meta(), 1'b0, 0);
        step(1'b1, nf_meta(), 1'b0, 0);

        // Same-cycle alloc of 2 with retire of 6, then alloc of 6 with response 6
        step(1'b0, '0, 1'b1, 2);
        step(1'b1, nf_meta(), 1'b1, 6);
        step(1'b1, nf_meta(), 1'b1, 6);

        // Leave 4 outstanding, then async reset between edges
        step(1'b0, '0, 1'b1, 0);
        step(1'b0, '0, 1'b1, 1);
        step(1'b0, '0, 1'b1, 3);
        step(1'b0, '0, 1'b1, 4);
        #2 rst = 1'b1;
        #1;
        chk("arst_outstanding", outstanding_cnt, 0);
        chk("arst_retire", rsp_retire, 0);
        chk("arst_init_done", init_done, 0);
        chk("arst_req_ready", req_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, '0, 1'b1, 5);
        repeat (N - 1) step(1'b0, '0, 1'b0, 0);
        step(1'b0, '0, 1'b1, 5);
        step(1'b1, nf_meta(), 1'b0, 0);

        repeat (400) begin
            v  = ($urandom_range(0, 3) != 0);
            f  = ($urandom_range(0, 7) == 0);
            rv = ($urandom_range(0, 1) == 1);
            step(v, f ? fence_meta() : nf_meta(), rv, int'($urandom_range(0, N - 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
